// File: rtl/vmem_pkg.sv
// vmem_pkg: shared sizes and FSM states for the rectangle-fill engine (WAIT_VB exists only with VMEM_FILL_VSYNC_EN)
package vmem_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int HW = 10;
  localparam int VW = 9;
  localparam int CW = 24;
  typedef enum logic [1:0] {
    IDLE,
`ifdef VMEM_FILL_VSYNC_EN
    WAIT_VB,
`endif
    FILL,
    DONE
  } state_t;
endpackage

// File: rtl/vmem_fill_clip.sv
// vmem_fill_clip: clips a rectangle to the visible area and flags commands that write nothing
module vmem_fill_clip
  import vmem_pkg::*;
(
  input  logic [HW-1:0] x,
  input  logic [VW-1:0] y,
  input  logic [HW-1:0] w,
  input  logic [VW-1:0] h,
  output logic [HW-1:0] x_end,
  output logic [VW-1:0] y_end,
  output logic          empty
);
  localparam logic [HW:0] HL = (HW+1)'(H_RES);
  localparam logic [VW:0] VL = (VW+1)'(V_RES);
  logic [HW:0] xs;
  logic [VW:0] ys;
  assign xs = {1'b0, x} + {1'b0, w};
  assign ys = {1'b0, y} + {1'b0, h};
  assign x_end = xs > HL ? HL[HW-1:0] : xs[HW-1:0];
  assign y_end = ys > VL ? VL[VW-1:0] : ys[VW-1:0];
  assign empty = w == '0 || h == '0 || {1'b0, x} >= HL || {1'b0, y} >= VL;
endmodule

// File: rtl/vmem_fill.sv
// vmem_fill: row-major solid rectangle fill into video memory; VMEM_FILL_VSYNC_EN holds each fill until vblank
module vmem_fill
  import vmem_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [HW-1:0] cmd_x,
  input  logic [VW-1:0] cmd_y,
  input  logic [HW-1:0] cmd_w,
  input  logic [VW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_color,
`ifdef VMEM_FILL_VSYNC_EN
  input  logic          vblank,
`endif
  output logic          wr_en,
  input  logic          wr_ready,
  output logic [HW-1:0] wr_h,
  output logic [VW-1:0] wr_v,
  output logic [CW-1:0] wr_data,
  output logic          busy,
  output logic          done
);
`ifdef VMEM_FILL_VSYNC_EN
  localparam state_t START = WAIT_VB;
`else
  localparam state_t START = FILL;
`endif
  state_t state, next;
  logic [HW-1:0] xs, xe, cx_end;
  logic [VW-1:0] ye, cy_end;
  logic c_empty, last_col, last_row, accept;
  vmem_fill_clip u_clip (
    .x(cmd_x),
    .y(cmd_y),
    .w(cmd_w),
    .h(cmd_h),
    .x_end(cx_end),
    .y_end(cy_end),
    .empty(c_empty)
  );
  assign cmd_ready = state == IDLE;
  assign wr_en = state == FILL;
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign accept = cmd_ready && cmd_valid;
  assign last_col = wr_h == xe - 1'b1;
  assign last_row = wr_v == ye - 1'b1;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next state: empty commands skip straight to DONE
  always_comb begin
    next = state;
    case (state)
      IDLE: next = cmd_valid ? (c_empty ? DONE : START) : IDLE;
`ifdef VMEM_FILL_VSYNC_EN
      WAIT_VB: next = vblank ? FILL : WAIT_VB;
`endif
      FILL: next = wr_ready && last_col && last_row ? DONE : FILL;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // latch the clipped command, then step the write position on each accepted write
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_h <= '0;
      wr_v <= '0;
      wr_data <= '0;
      xs <= '0;
      xe <= '0;
      ye <= '0;
    end else if (accept) begin
      wr_h <= cmd_x;
      wr_v <= cmd_y;
      wr_data <= cmd_color;
      xs <= cmd_x;
      xe <= cx_end;
      ye <= cy_end;
    end else if (wr_en && wr_ready && !(last_col && last_row)) begin
      wr_h <= last_col ? xs : wr_h + 1'b1;
      wr_v <= last_col ? wr_v + 1'b1 : wr_v;
    end
endmodule

// File: doc/vmem_fill.md
# vmem_fill

Rectangle-fill engine that writes solid colour into the video memory ahead of the VGA scan-out path. Accepts one fill command at a time over a valid/ready handshake, clips it to the visible 640x480 area, and drives the video memory write port one pixel per cycle in row-major order, honouring write-port backpressure. Sits upstream of the video memory; the VGA controller keeps reading the same memory through its own read port.

## Interface
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  fill command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  10  left column of rectangle
- cmd_y  in  9  top line of rectangle
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in lines
- cmd_color  in  24  fill colour, {R,G,B} 8 bits each
- wr_en  out  1  write request to video memory
- wr_ready  in  1  video memory accepts the write this cycle
- wr_h  out  10  write column
- wr_v  out  9  write line
- wr_data  out  24  write colour
- busy  out  1  command accepted, not yet finished
- done  out  1  one-cycle pulse when a command completes
- vblank  in  1  vertical blanking indicator (present only with VMEM_FILL_VSYNC_EN)

## Operation
- States: IDLE, WAIT_VB (macro only), FILL, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch colour and clipped bounds; next state FILL (or WAIT_VB).
- Clipping: x_end = min(cmd_x+cmd_w, H_RES), y_end = min(cmd_y+cmd_h, V_RES), sums in 11/10 bits, no wrap. Empty if cmd_w==0, cmd_h==0, cmd_x>=H_RES or cmd_y>=V_RES; empty command goes straight to DONE with zero writes.
- FILL: wr_en=1, wr_h/wr_v = current column/line, wr_data = latched colour. Position advances only when wr_en&wr_ready. Column increments; at x_end-1 it returns to cmd_x and line increments. Write at (x_end-1, y_end-1) accepted -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- cmd_ready=0 in every state except IDLE; commands presented while busy are held by the sender, not dropped.
- busy=1 in WAIT_VB, FILL, DONE.
- wr_h/wr_v/wr_data stable while wr_en=1 and wr_ready=0.

## Timing
- Reset values: state IDLE, cmd_ready=1, wr_en=0, wr_h=0, wr_v=0, wr_data=0, busy=0, done=0.
- All outputs registered or decoded from registered state; no combinational path from cmd_* or wr_ready to any output.
- Command accepted at edge T -> wr_en=1 from cycle T+1 (no macro).
- With wr_ready held high: W*H writes in consecutive cycles; done in the cycle after the last accepted write; cmd_ready returns the cycle after done. Total T+1 .. T+W*H+1.
- Empty command: done in cycle T+1, no wr_en.
- Reset mid-fill: wr_en drops immediately (async); the partially written rectangle remains; no done pulse.

## Configuration
- VMEM_FILL_VSYNC_EN defined: vblank port exists; after accept, WAIT_VB until vblank=1, then FILL; fill continues after vblank falls (no tearing guarantee past blanking). Empty commands skip WAIT_VB.
- Undefined: no vblank port, no WAIT_VB state; FILL directly after accept.

## Structure
- Package vmem_pkg: H_RES/V_RES defaults, coordinate widths (10 h, 9 v), colour width 24, state enum.
- One sub-module vmem_fill_clip: combinational clipping of x/y/w/h to x_end, y_end, empty flag.

## Test plan
- Reset, then cmd (x=10,y=20,w=3,h=2,color=24'hFF0000), wr_ready=1 -> 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all data FF0000; done one cycle after last; cmd_ready back next cycle.
- Clip: x=638,y=479,w=5,h=4 -> exactly 2 writes (638,479),(639,479), then done.
- Empty: w=0 or x=640 -> no wr_en, done at T+1.
- Backpressure: w=4,h=1, wr_ready toggling 1,0,0,1,... -> outputs hold while stalled, 4 distinct writes, none duplicated or skipped.
- Second cmd_valid held during fill -> not accepted until after done; then executes normally.
- Macro build: accept with vblank=0 -> no writes for 50 cycles; raise vblank -> writes start next cycle.
